// File: rtl/uart_imem_loader_if.sv
// Boot-loader port bundle: UART receive strobe in, four byte-lane SRAM macro pins
// and loader status out. master = loader side, slave = UART/macro/mux side.
interface uart_imem_loader_if #(
  parameter int AW = 9
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          cen  [0:3];
  logic          gwen [0:3];
  logic [7:0]    wen  [0:3];
  logic [AW-1:0] a    [0:3];
  logic [7:0]    d    [0:3];
  logic          busy;
  logic          done;
  logic          error;
  logic          core_rst;

  modport master (
    input  rx_data, rx_valid,
    output cen, gwen, wen, a, d, busy, done, error, core_rst
  );

  modport slave (
    output rx_data, rx_valid,
    input  cen, gwen, wen, a, d, busy, done, error, core_rst
  );
endinterface

// File: rtl/uart_imem_loader.sv
// UART boot loader: assembles little-endian words and writes them into four byte-lane
// SRAM macros. Define UART_IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
//
// state  | meaning
// IDLE   | discarding bytes until magic 0xA5
// LEN_LO | expecting word count low byte
// LEN_HI | expecting word count high byte, then range check
// DATA   | collecting the 4 bytes of a word
// WRITE  | one-cycle macro write of the assembled word
// CHECK  | expecting checksum byte (checksum build only)
// DONE   | image loaded, core released (terminal)
// ERROR  | protocol/length/timeout failure (terminal)
module uart_imem_loader #(
  parameter int DEPTH          = 512,
  parameter int AW             = 9,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                clk,
  input logic                rst,
  uart_imem_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  // Down-counter hits zero on the cycle that the idle count reaches TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE,
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE, ERROR
  } state_t;

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN_STATE = CHECK;
`else
  localparam state_t FIN_STATE = DONE;
`endif

  state_t        state, next_state;
  logic [TW-1:0] tmr;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [AW-1:0] word_addr;
  logic [16:0]   wcnt;
  logic [1:0]    idx;
  logic [7:0]    wbuf [0:3];
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  logic [15:0] len_rx;
  logic        counting;
  logic        tmo;
  logic        last_word;
  logic        busy_next;

  always_comb begin
    len_rx     = {bus.rx_data, len_lo};
    counting   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    busy_next  = (next_state == LEN_LO) || (next_state == LEN_HI) ||
                 (next_state == DATA) || (next_state == WRITE);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    if (state == CHECK) counting = 1'b1;
    if (next_state == CHECK) busy_next = 1'b1;
`endif
    tmo        = counting && !bus.rx_valid && (tmr == '0);
    last_word  = (wcnt + 17'd1) == {1'b0, len};
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == 8'hA5) next_state = LEN_LO;
      end
      LEN_LO: begin
        if (bus.rx_valid) next_state = LEN_HI;
        else if (tmo)     next_state = ERROR;
      end
      LEN_HI: begin
        if (bus.rx_valid) begin
          if ({1'b0, len_rx} > 17'(DEPTH)) next_state = ERROR;
          else if (len_rx == 16'd0)        next_state = FIN_STATE;
          else                             next_state = DATA;
        end else if (tmo) begin
          next_state = ERROR;
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          if (idx == 2'd3) next_state = WRITE;
        end else if (tmo) begin
          next_state = ERROR;
        end
      end
      WRITE: begin
        next_state = last_word ? FIN_STATE : DATA;
      end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (bus.rx_valid) next_state = (bus.rx_data == sum) ? DONE : ERROR;
        else if (tmo)     next_state = ERROR;
      end
`endif
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      len_lo    <= '0;
      len       <= '0;
      word_addr <= '0;
      wcnt      <= '0;
      idx       <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
      for (int i = 0; i < 4; i++) begin
        wbuf[i]     <= '0;
        bus.cen[i]  <= 1'b1;
        bus.gwen[i] <= 1'b1;
        bus.wen[i]  <= 8'hFF;
        bus.a[i]    <= '0;
        bus.d[i]    <= '0;
      end
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      bus.core_rst <= 1'b1;
    end else begin
      state <= next_state;

      if (bus.rx_valid)              tmr <= TMR_LOAD;
      else if (counting && tmr != '0) tmr <= tmr - TW'(1);

      case (state)
        LEN_LO: begin
          if (bus.rx_valid) len_lo <= bus.rx_data;
        end
        LEN_HI: begin
          if (bus.rx_valid) begin
            len       <= len_rx;
            word_addr <= '0;
            wcnt      <= '0;
            idx       <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            wbuf[idx] <= bus.rx_data;
            idx       <= idx + 2'd1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            sum       <= sum + bus.rx_data;
`endif
          end
        end
        WRITE: begin
          word_addr <= word_addr + AW'(1);
          wcnt      <= wcnt + 17'd1;
          // A byte landing on the write cycle starts the next word; after the last word it is dropped.
          if (bus.rx_valid && next_state == DATA) begin
            wbuf[0] <= bus.rx_data;
            idx     <= 2'd1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            sum     <= sum + bus.rx_data;
`endif
          end
        end
        default: ;
      endcase

      for (int i = 0; i < 4; i++) begin
        if (next_state == WRITE) begin
          bus.cen[i]  <= 1'b0;
          bus.gwen[i] <= 1'b0;
          bus.wen[i]  <= 8'h00;
          bus.a[i]    <= word_addr;
          bus.d[i]    <= (i == 3) ? bus.rx_data : wbuf[i];
        end else begin
          bus.cen[i]  <= 1'b1;
          bus.gwen[i] <= 1'b1;
          bus.wen[i]  <= 8'hFF;
          bus.a[i]    <= '0;
          bus.d[i]    <= '0;
        end
      end

      bus.busy     <= busy_next;
      bus.done     <= (next_state == DONE);
      bus.error    <= (next_state == ERROR);
      bus.core_rst <= (next_state != DONE);
    end
  end
endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Boot loader that receives a program image as a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them into the four byte-lane instruction SRAM macros through their native macro pins. It sits between the UART receive path (`rx_data`/`outValid`) and the instruction-memory macro port mux. It holds the core in reset until the image is fully written, which makes it the write-side counterpart to the read-only instruction fetch path.

## Interface
- `DEPTH`, 512: words per macro set; upper bound on the image word count.
- `AW`, 9: macro word-address width.
- `TIMEOUT_CYCLES`, 1000000: maximum number of idle cycles allowed between bytes once a load has started.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe that marks a received byte.
- `cen[0:3]` out 1 each: macro chip enable, active-low.
- `gwen[0:3]` out 1 each: macro global write enable, active-low.
- `wen[0:3]` out 8 each: macro bit write enables, active-low.
- `a[0:3]` out AW each: macro word address.
- `d[0:3]` out 8 each: macro write data. Lane i carries byte i of the word.
- `busy` out 1: high from magic-byte acceptance until DONE or ERROR; the external mux gives the loader the macro pins while this is high.
- `done` out 1: image loaded successfully. Sticky until reset.
- `error` out 1: protocol, length or timeout failure. Sticky until reset.
- `core_rst` out 1: reset request to the core. Equals `!done`.

## Operation
- Frame format, in byte order: magic 0xA5; word count N as a 16-bit little-endian value (low byte first); N×4 data bytes, each word little-endian; optional checksum (see Configuration).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE
  - On `rx_valid`, 0xA5 moves to LEN_LO.
  - Any other byte is discarded and the FSM stays in IDLE. No timeout applies here.
- LEN_LO: the byte is captured as `len[7:0]`; move to LEN_HI.
- LEN_HI: the byte is captured as `len[15:8]`. The completed length then selects the next state:
  - len > DEPTH → ERROR.
  - len == 0 → CHECK if the checksum option is compiled in, otherwise DONE.
  - otherwise → DATA, with word address = 0 and lane index = 0.
- DATA
  - Each byte is stored into lane `idx` of the word buffer and `idx` increments (2 bits).
  - On the 4th byte (`idx` == 3) the FSM moves to WRITE.
- WRITE lasts exactly one cycle and drives the write:
  - All `cen` = 0, all `gwen` = 0, all `wen` = 8'h00.
  - `a[i]` = word address.
  - `d[i]` = buffer lane i.
  - A byte arriving in this cycle is captured as lane 0 of the next word, and `idx` becomes 1.
- Leaving WRITE: word address increments. Once the written-word count equals len, go to CHECK or DONE; otherwise return to DATA.
- Idle macro pins (every state except WRITE): `cen` = 1, `gwen` = 1, `wen` = 8'hFF, `a` = 0, `d` = 0.
- Timeout
  - A counter clears on every `rx_valid` and counts only in LEN_LO, LEN_HI, DATA and CHECK.
  - Reaching TIMEOUT_CYCLES-1 without a byte moves the FSM to ERROR.
- DONE and ERROR are terminal until `rst`. All later bytes are ignored.
- Bytes received after the final word while the FSM is still busy are ignored. Data bytes are never written past word address len-1.

## Timing
- Reset values: `cen` = 1, `gwen` = 1, `wen` = 8'hFF, `a` = 0, `d` = 0, `busy` = 0, `done` = 0, `error` = 0, `core_rst` = 1. FSM = IDLE, all counters = 0.
- Macro write strobe is asserted the cycle after the `rx_valid` of the 4th byte of a word and lasts 1 cycle. All outputs are registered.
- `done` rises 1 cycle after the final WRITE cycle, or after checksum acceptance. `core_rst` falls in the same cycle. `busy` falls in the same cycle `done` or `error` rises.
- Arithmetic: the written-word counter is 17 bits, so there is no wrap at len = 65535 (that value is rejected as > DEPTH anyway). Word address is AW bits; it never wraps because len ≤ DEPTH.
- Reset mid-frame aborts immediately: the FSM returns to IDLE and any partial word is discarded. Words already written remain in the SRAM.

## Configuration
- `UART_IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last word the FSM enters CHECK and waits for one checksum byte.
  - The checksum is the 8-bit sum, mod 256, of all data bytes (magic and length bytes excluded).
  - Match → DONE. Mismatch → ERROR. Timeout applies in CHECK.
- Not defined: the CHECK state and sum register are absent, and the FSM goes straight to DONE after the last word.

## Test plan
- Bytes A5 01 00 78 56 34 12 (plus checksum 0x14 if `_EN` is defined) → exactly one write cycle with `a` = 0 and d[0..3] = 78, 56, 34, 12; `done` = 1; `core_rst` = 0; `error` = 0.
- Bytes 00 FF then A5 02 00 followed by 8 data bytes → garbage before the magic is ignored; writes occur at addresses 0 and 1; `done` asserts once.
- Length 0x0201 (513) → `error` = 1; no macro writes; `core_rst` stays at 1.
- Stream stops after 2 data bytes, with TIMEOUT_CYCLES = 16 → `error` = 1 exactly 15 cycles after the last `rx_valid`.
- `rst` pulsed after 3 data bytes, then a full 1-word frame sent → only the new word is written, at address 0; `done` = 1.
- `_EN` defined, 1-word frame with wrong checksum (0x15) → word is written but `error` = 1 and `done` = 0.
